// File: rtl/key_step_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : key_step_conditioner                                            |
// | Purpose  : Conditions a raw active-low pushbutton and a raw direction      |
// |            switch for the HEX digit-sequencer. Both inputs are            |
// |            synchronised and the button is debounced. Each accepted press  |
// |            produces a one-cycle step pulse, and the direction is latched  |
// |            on that pulse, so the sequencer can advance on a clock enable. |
// | Optional : `define AUTO_REPEAT_EN adds auto-repeat steps while the button  |
// |            stays held (first after HOLD_CYCLES, then every REPEAT_CYCLES).|
// | Ports    : clk     - board clock, rising edge                             |
// |            reset   - asynchronous active-low reset                        |
// |            key_n   - raw pushbutton, active-low, bouncy                   |
// |            dir_in  - raw direction switch                                 |
// |            step    - registered one-cycle advance pulse                   |
// |            pressed - debounced button level (1 = held)                    |
// |            dir_out - direction latched on every step pulse                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module key_step_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  input  logic dir_in,
  output logic step,
  output logic pressed,
  output logic dir_out
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Parameters below 2 would allow back-to-back step pulses or a zero-width counter.
  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
    $error("key_step_conditioner: all cycle parameters must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       key_sync;
  logic [1:0]       dir_sync;
  logic             key_s;
  logic             dir_s;

  // Key flops reset to 1 so a reset is seen as "button released".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_sync <= 2'b11;
      dir_sync <= 2'b00;
    end else begin
      key_sync <= {key_sync[0], key_n};
      dir_sync <= {dir_sync[0], dir_in};
    end
  end

  assign key_s = ~key_sync[1];
  assign dir_s = dir_sync[1];

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] HOLD_LAST = RPT_W'(HOLD_CYCLES - 1);
  localparam logic [RPT_W-1:0] REP_LAST  = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_first;  // still waiting for the first (longer) hold interval
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      step      <= 1'b0;
      pressed   <= 1'b0;
      dir_out   <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
`endif
    end else begin
      step <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (key_s) state <= PRESS_CHK;
        end

        PRESS_CHK: begin
          if (!key_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= HELD;
            cnt     <= '0;
            step    <= 1'b1;
            pressed <= 1'b1;
            dir_out <= dir_s;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HELD: begin
          cnt <= '0;
          if (!key_s) state <= REL_CHK;
`ifdef AUTO_REPEAT_EN
          // Any exit from HELD restarts the long first-repeat wait.
          if (!key_s) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
          end else if (rpt_cnt == (rpt_first ? HOLD_LAST : REP_LAST)) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
            step      <= 1'b1;
            dir_out   <= dir_s;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
`endif
        end

        REL_CHK: begin
          if (key_s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= IDLE;
            cnt     <= '0;
            pressed <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          cnt     <= '0;
          pressed <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
